mdu: RTL

MDU -- requirements
Module: mdu

---
 rtl/mdu_pkg.sv | 7 +
 rtl/mdu_if.sv | 14 +
 rtl/mdu_iter.sv | 35 +++
 rtl/mdu.sv | 88 ++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, FSM states and iteration count shared by the MDU and decode.
package mdu_pkg;
  localparam int MDU_ITER = 32;
  typedef enum logic [1:0] {MUL = 2'b00, MULH = 2'b01, MULHSU = 2'b10, MULHU = 2'b11} mul_op_e;
  typedef enum logic [1:0] {DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11} div_op_e;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_e;
endpackage

// File: rtl/mdu_if.sv
// mdu_if: decode/hazard-side request, flush and completion signals of the MDU.
interface mdu_if;
  logic        start_m;
  logic        start_d;
  logic [1:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        flush;
  logic        fin;
  logic [31:0] result;
  logic        busy;
  modport master (output start_m, start_d, op, src1, src2, flush, input fin, result, busy);
  modport slave (input start_m, start_d, op, src1, src2, flush, output fin, result, busy);
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: radix-2 engine; 64-bit shift register plus one 33-bit adder/subtractor
// doing shift-add multiply or restoring divide ({remainder, quotient} layout).
module mdu_iter (
  input  logic        clk,
  input  logic        rstn,
  input  logic        load,
  input  logic        step,
  input  logic        is_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] acc
);
  logic [63:0] acc_q, acc_d;
  logic [31:0] b_q, b_d;
  logic [32:0] op_a, op_b, sum;
  always_comb begin
    op_a = is_div ? acc_q[63:31] : {1'b0, acc_q[63:32]};
    op_b = is_div ? ~{1'b0, b_q} : (acc_q[0] ? {1'b0, b_q} : 33'd0);
    sum = op_a + op_b + {32'd0, is_div};
    // divide: sum[32] set means the trial subtract went negative, so keep the shifted remainder
    acc_d = load ? {32'd0, a} : !step ? acc_q : !is_div ? {sum, acc_q[31:1]} :
            sum[32] ? {acc_q[62:0], 1'b0} : {sum[31:0], acc_q[30:0], 1'b1};
    b_d = load ? b : b_q;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_q <= '0;
      b_q <= '0;
    end else begin
      acc_q <= acc_d;
      b_q <= b_d;
    end
  end
  assign acc = acc_q;
endmodule

// File: rtl/mdu.sv
// mdu: iterative RV32M multiply/divide unit; FSM, sign fix-up and special cases.
// MDU_FASTPATH_EN: divide-by-zero, signed overflow and mul-by-zero finish one cycle after accept.
module mdu
  import mdu_pkg::*;
(
  input logic  clk,
  input logic  rstn,
  mdu_if.slave bus
);
  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic        div_q, div_d, s1_q, s1_d, s2_q, s2_d, spec_q, spec_d;
  logic [31:0] spec_r_q, spec_r_d, result_q, result_d;
  logic        accept, is_mul, sgn1, sgn2, dz, ovf, mz, special, fast;
  logic [31:0] mag1, mag2, final_r;
  logic [63:0] acc, prod;
  mdu_iter u_iter (
    .clk   (clk),
    .rstn  (rstn),
    .load  (accept),
    .step  (state_q == RUN),
    .is_div(div_q),
    .a     (mag1),
    .b     (mag2),
    .acc   (acc)
  );
  always_comb begin
    accept = state_q == IDLE && (bus.start_m || bus.start_d) && !bus.flush;
    is_mul = bus.start_m;
    sgn1 = bus.src1[31] && (is_mul ? bus.op != MULHU : !bus.op[0]);
    sgn2 = bus.src2[31] && (is_mul ? (bus.op == MUL || bus.op == MULH) : !bus.op[0]);
    mag1 = sgn1 ? -bus.src1 : bus.src1;
    mag2 = sgn2 ? -bus.src2 : bus.src2;
    dz = !is_mul && bus.src2 == '0;
    ovf = !is_mul && !bus.op[0] && bus.src1 == 32'h8000_0000 && bus.src2 == '1;
    mz = is_mul && (bus.src1 == '0 || bus.src2 == '0);
    special = dz || ovf || mz;
`ifdef MDU_FASTPATH_EN
    fast = special;
`else
    fast = 1'b0;
`endif
    prod = (s1_q ^ s2_q) ? -acc : acc;
    final_r = spec_q ? spec_r_q :
              !div_q ? (op_q == MUL ? prod[31:0] : prod[63:32]) :
              op_q[1] ? (s1_q ? -acc[63:32] : acc[63:32]) :
              ((s1_q ^ s2_q) ? -acc[31:0] : acc[31:0]);
    bus.fin = state_q == DONE && !bus.flush;
    bus.result = bus.fin ? final_r : result_q;
    bus.busy = state_q != IDLE;
    state_d = bus.flush ? IDLE : accept ? (fast ? DONE : RUN) :
              state_q == RUN ? (cnt_q == 5'(MDU_ITER - 1) ? DONE : RUN) :
              state_q == DONE ? IDLE : state_q;
    cnt_d = accept ? 5'd0 : state_q == RUN ? cnt_q + 5'd1 : cnt_q;
    op_d = accept ? bus.op : op_q;
    div_d = accept ? !is_mul : div_q;
    s1_d = accept ? sgn1 : s1_q;
    s2_d = accept ? sgn2 : s2_q;
    spec_d = accept ? special : spec_q;
    spec_r_d = !accept ? spec_r_q : dz ? (bus.op[1] ? bus.src1 : '1) :
               ovf ? (bus.op[1] ? 32'd0 : 32'h8000_0000) : 32'd0;
    result_d = bus.fin ? final_r : result_q;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= '0;
      div_q <= 1'b0;
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      spec_q <= 1'b0;
      spec_r_q <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      div_q <= div_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      spec_q <= spec_d;
      spec_r_q <= spec_r_d;
      result_q <= result_d;
    end
  end
endmodule
